// File: rtl/gpu_cmd_pkg.sv
// Shared types and constants for the gpu APB command master.
// Command words carry an opcode plus x/y coordinates for the drawing engine.
package gpu_cmd_pkg;

    localparam logic [3:0] CMD_SET_XY1   = 4'b0001;
    localparam logic [3:0] CMD_SET_XY2   = 4'b0010;
    localparam logic [3:0] CMD_DRAW_LINE = 4'b0100;

    localparam int OP_MSB = 31;
    localparam int OP_LSB = 28;
    localparam int Y_MSB  = 18;
    localparam int Y_LSB  = 10;
    localparam int X_MSB  = 9;
    localparam int X_LSB  = 0;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } apb_state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } cmd_entry_t;

    function automatic logic [3:0] cmd_opcode(input logic [31:0] word);
        return word[OP_MSB:OP_LSB];
    endfunction

endpackage

// File: rtl/gpu_apb_cmd_master_if.sv
// Command handshake plus APB write bus of the gpu command master.
// The master modport is the DUT view; slave is the upstream/APB environment.
interface gpu_apb_cmd_master_if;

    logic        cmd_valid_i;
    logic [31:0] cmd_addr_i;
    logic [31:0] cmd_data_i;
    logic        cmd_ready_o;
    logic        stall_i;
    logic        pReady_i;
    logic [31:0] pAddr_o;
    logic [31:0] pDataWrite_o;
    logic        pSel_o;
    logic        pEnable_o;
    logic        pWrite_o;
    logic        done_o;
    logic        err_o;
    logic        err_clr_i;
    logic        busy_o;

    modport master (
        input  cmd_valid_i, cmd_addr_i, cmd_data_i, stall_i, pReady_i, err_clr_i,
        output cmd_ready_o, pAddr_o, pDataWrite_o, pSel_o, pEnable_o, pWrite_o,
               done_o, err_o, busy_o
    );

    modport slave (
        output cmd_valid_i, cmd_addr_i, cmd_data_i, stall_i, pReady_i, err_clr_i,
        input  cmd_ready_o, pAddr_o, pDataWrite_o, pSel_o, pEnable_o, pWrite_o,
               done_o, err_o, busy_o
    );

endinterface

// File: rtl/gpu_apb_cmd_master_fifo.sv
// Command FIFO holding address+data pairs; pointers carry an extra wrap bit.
// head_next exposes the entry behind the head so back-to-back transfers can load it.
module cmd_fifo
    import gpu_cmd_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       n_rst,
    input  logic                       push,
    input  cmd_entry_t                 push_entry,
    input  logic                       pop,
    output cmd_entry_t                 head,
    output cmd_entry_t                 head_next,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);

    cmd_entry_t      mem [DEPTH];
    logic [AW:0]     wr_ptr;
    logic [AW:0]     rd_ptr;
    logic [AW-1:0]   rd_next_idx;
    logic            do_push;
    logic            do_pop;

    assign full        = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty       = (wr_ptr == rd_ptr);
    assign count       = wr_ptr - rd_ptr;
    assign do_push     = push && !full;
    assign do_pop      = pop && !empty;
    assign rd_next_idx = rd_ptr[AW-1:0] + 1'b1;
    assign head        = mem[rd_ptr[AW-1:0]];
    assign head_next   = mem[rd_next_idx];

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_entry;
    end

endmodule

// File: rtl/gpu_apb_cmd_master.sv
// APB write initiator draining queued gpu commands, with wait-state timeout and stall.
module gpu_apb_cmd_master #(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic                 clk,
    input  logic                 n_rst,
    gpu_apb_cmd_master_if.master bus
);

    import gpu_cmd_pkg::*;

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam int PW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] WAIT_LIMIT = CW'(TIMEOUT - 1);

    apb_state_t    state;
    apb_state_t    state_next;
    cmd_entry_t    push_entry;
    cmd_entry_t    head;
    cmd_entry_t    head_next;
    logic [PW-1:0] count;
    logic          full;
    logic          empty;
    logic          more_queued;
    logic          xfer_ok;
    logic          timeout_hit;
    logic [CW-1:0] wait_cnt;
    logic [31:0]   addr_q;
    logic [31:0]   data_q;
    logic          done_q;
    logic          err_q;
    logic          sel;
    logic          enable;

    assign push_entry  = '{addr: bus.cmd_addr_i, data: bus.cmd_data_i};
    assign more_queued = (count > PW'(1));
    assign xfer_ok     = (state == ACCESS) && bus.pReady_i;
    assign timeout_hit = (state == ACCESS) && !bus.pReady_i && (wait_cnt >= WAIT_LIMIT);

    cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk        (clk),
        .n_rst      (n_rst),
        .push       (bus.cmd_valid_i),
        .push_entry (push_entry),
        .pop        (xfer_ok || timeout_hit),
        .head       (head),
        .head_next  (head_next),
        .count      (count),
        .full       (full),
        .empty      (empty)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (!empty && !bus.stall_i) state_next = SETUP;
            SETUP:   state_next = ACCESS;
            ACCESS: begin
                if (xfer_ok)          state_next = (more_queued && !bus.stall_i) ? SETUP : IDLE;
                else if (timeout_hit) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        sel    = (state != IDLE);
        enable = (state == ACCESS);
    end

    // Back-to-back SETUP takes the entry behind the one being popped this edge.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            addr_q <= '0;
            data_q <= '0;
        end else if (state == IDLE && state_next == SETUP) begin
            addr_q <= head.addr;
            data_q <= head.data;
        end else if (state == ACCESS && state_next == SETUP) begin
            addr_q <= head_next.addr;
            data_q <= head_next.data;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wait_cnt <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            done_q <= xfer_ok;
            if (state == ACCESS && !bus.pReady_i && !timeout_hit) begin
                if (wait_cnt != '1) wait_cnt <= wait_cnt + 1'b1;
            end else begin
                wait_cnt <= '0;
            end
            if (timeout_hit)        err_q <= 1'b1;
            else if (bus.err_clr_i) err_q <= 1'b0;
        end
    end

    assign bus.cmd_ready_o  = !full;
    assign bus.pAddr_o      = addr_q;
    assign bus.pDataWrite_o = data_q;
    assign bus.pSel_o       = sel;
    assign bus.pEnable_o    = enable;
    assign bus.pWrite_o     = sel;
    assign bus.done_o       = done_q;
    assign bus.err_o        = err_q;
    assign bus.busy_o       = !empty || (state != IDLE);

endmodule

// File: tb/tb_gpu_apb_cmd_master.sv
// Directed self-checking bench for gpu_apb_cmd_master (FIFO_DEPTH=4, TIMEOUT=16).
module tb_gpu_apb_cmd_master;

    import gpu_cmd_pkg::*;

    logic tb_clk;
    logic n_rst;
    int   checks;
    int   errors;
    int   done_count;
    int   sel_count;
    int   xfer_idx;

    gpu_apb_cmd_master_if bus();

    gpu_apb_cmd_master #(.FIFO_DEPTH(4), .TIMEOUT(16)) dut (
        .clk   (tb_clk),
        .n_rst (n_rst),
        .bus   (bus.master)
    );

    initial begin
        tb_clk = 1'b0;
        forever #5 tb_clk = ~tb_clk;
    end

    task automatic tick();
        @(posedge tb_clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic check_bit(input string tag, input logic observed, input logic expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
        end
    endtask

    task automatic apply_stimulus(input logic valid, input logic [31:0] addr, input logic [31:0] data);
        bus.cmd_valid_i = valid;
        bus.cmd_addr_i  = addr;
        bus.cmd_data_i  = data;
    endtask

    // Expected sequences for the back-to-back triple, indexed by cycle after push A.
    logic        exp_sel [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic        exp_en  [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic        exp_done[8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] exp_data[8] = '{32'h0, 32'h1000_0000, 32'h1000_0000, 32'h2002_A4C8,
                                 32'h2002_A4C8, 32'h40AA_BD3E, 32'h40AA_BD3E, 32'h0};
    logic [31:0] exp_addr[8] = '{32'h0, 32'h10, 32'h10, 32'h14, 32'h14, 32'h18, 32'h18, 32'h0};

    initial begin
        checks = 0;
        errors = 0;
        n_rst  = 1'b1;
        apply_stimulus(1'b0, 32'h0, 32'h0);
        bus.stall_i   = 1'b0;
        bus.pReady_i  = 1'b1;
        bus.err_clr_i = 1'b0;
        #1 n_rst = 1'b0;
        tick();
        tick();

        $display("[TB] reset state");
        check_bit("rst_ready",  bus.cmd_ready_o, 1'b1);
        check_bit("rst_sel",    bus.pSel_o,      1'b0);
        check_bit("rst_enable", bus.pEnable_o,   1'b0);
        check_bit("rst_write",  bus.pWrite_o,    1'b0);
        check_bit("rst_done",   bus.done_o,      1'b0);
        check_bit("rst_err",    bus.err_o,       1'b0);
        check_bit("rst_busy",   bus.busy_o,      1'b0);
        n_rst = 1'b1;
        tick();

        $display("[TB] single zero-wait write");
        apply_stimulus(1'b1, 32'h0, 32'h1000_0000);
        tick();
        apply_stimulus(1'b0, 32'h0, 32'h0);
        check_bit("single_e0_sel",  bus.pSel_o, 1'b0);
        check_bit("single_e0_busy", bus.busy_o, 1'b1);
        tick();
        check_bit("single_e1_sel",    bus.pSel_o,    1'b1);
        check_bit("single_e1_enable", bus.pEnable_o, 1'b0);
        check_bit("single_e1_write",  bus.pWrite_o,  1'b1);
        check_output("single_e1_addr", bus.pAddr_o,      32'h0);
        check_output("single_e1_data", bus.pDataWrite_o, 32'h1000_0000);
        tick();
        check_bit("single_e2_enable", bus.pEnable_o, 1'b1);
        check_bit("single_e2_sel",    bus.pSel_o,    1'b1);
        tick();
        check_bit("single_e3_sel",  bus.pSel_o, 1'b0);
        check_bit("single_e3_done", bus.done_o, 1'b1);
        check_bit("single_e3_busy", bus.busy_o, 1'b0);
        tick();
        check_bit("single_e4_done", bus.done_o, 1'b0);

        $display("[TB] back-to-back triple");
        done_count = 0;
        sel_count  = 0;
        apply_stimulus(1'b1, 32'h10, 32'h1000_0000);
        for (int i = 0; i < 8; i++) begin
            tick();
            if (i == 0) apply_stimulus(1'b1, 32'h14, 32'h2002_A4C8);
            if (i == 1) apply_stimulus(1'b1, 32'h18, 32'h40AA_BD3E);
            if (i == 2) apply_stimulus(1'b0, 32'h0, 32'h0);
            check_bit($sformatf("b2b_sel_%0d", i),  bus.pSel_o,    exp_sel[i]);
            check_bit($sformatf("b2b_en_%0d", i),   bus.pEnable_o, exp_en[i]);
            check_bit($sformatf("b2b_done_%0d", i), bus.done_o,    exp_done[i]);
            if (exp_sel[i]) begin
                check_output($sformatf("b2b_addr_%0d", i), bus.pAddr_o,      exp_addr[i]);
                check_output($sformatf("b2b_data_%0d", i), bus.pDataWrite_o, exp_data[i]);
            end
            if (i == 3) begin
                check_output("b2b_opcode", 32'(cmd_opcode(bus.pDataWrite_o)), 32'(CMD_SET_XY2));
                check_output("b2b_x", 32'(bus.pDataWrite_o[X_MSB:X_LSB]), 32'd200);
                check_output("b2b_y", 32'(bus.pDataWrite_o[Y_MSB:Y_LSB]), 32'd169);
            end
            if (bus.done_o) done_count++;
            if (bus.pSel_o) sel_count++;
        end
        check_output("b2b_done_count", 32'(done_count), 32'd3);
        check_output("b2b_sel_cycles", 32'(sel_count),  32'd6);
        check_bit("b2b_busy_end", bus.busy_o, 1'b0);

        $display("[TB] fifo full under stall");
        bus.stall_i = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            apply_stimulus(1'b1, 32'h100 + 32'(k * 4), 32'h1000_0000 | 32'(k));
            tick();
            check_bit($sformatf("full_ready_%0d", k), bus.cmd_ready_o, (k < 4) ? 1'b1 : 1'b0);
        end
        check_bit("full_sel_stalled", bus.pSel_o, 1'b0);
        apply_stimulus(1'b0, 32'h0, 32'h0);
        bus.stall_i = 1'b0;
        done_count = 0;
        xfer_idx   = 1;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (bus.pSel_o && !bus.pEnable_o) begin
                check_output($sformatf("full_addr_%0d", xfer_idx), bus.pAddr_o, 32'h100 + 32'(xfer_idx * 4));
                check_output($sformatf("full_data_%0d", xfer_idx), bus.pDataWrite_o, 32'h1000_0000 | 32'(xfer_idx));
                xfer_idx++;
            end
            if (bus.done_o) done_count++;
        end
        check_output("full_done_count", 32'(done_count), 32'd4);
        check_bit("full_busy_end",  bus.busy_o,      1'b0);
        check_bit("full_ready_end", bus.cmd_ready_o, 1'b1);

        $display("[TB] wait states");
        bus.pReady_i = 1'b0;
        apply_stimulus(1'b1, 32'h200, 32'h4000_1234);
        tick();
        apply_stimulus(1'b0, 32'h0, 32'h0);
        tick();
        check_bit("wait_setup_sel", bus.pSel_o, 1'b1);
        tick();
        check_bit("wait_access_en", bus.pEnable_o, 1'b1);
        for (int w = 0; w < 3; w++) begin
            tick();
            check_bit($sformatf("wait_en_%0d", w),   bus.pEnable_o, 1'b1);
            check_bit($sformatf("wait_done_%0d", w), bus.done_o,    1'b0);
            check_output($sformatf("wait_addr_%0d", w), bus.pAddr_o,      32'h200);
            check_output($sformatf("wait_data_%0d", w), bus.pDataWrite_o, 32'h4000_1234);
        end
        bus.pReady_i = 1'b1;
        tick();
        check_bit("wait_done", bus.done_o, 1'b1);
        check_bit("wait_sel",  bus.pSel_o, 1'b0);
        check_bit("wait_err",  bus.err_o,  1'b0);

        $display("[TB] timeout");
        bus.pReady_i = 1'b0;
        apply_stimulus(1'b1, 32'h300, 32'h1000_0300);
        tick();
        apply_stimulus(1'b1, 32'h304, 32'h4AAA_0001);
        tick();
        apply_stimulus(1'b0, 32'h0, 32'h0);
        tick();
        check_bit("to_access_en", bus.pEnable_o, 1'b1);
        repeat (15) tick();
        check_bit("to_before_sel", bus.pSel_o,    1'b1);
        check_bit("to_before_en",  bus.pEnable_o, 1'b1);
        check_bit("to_before_err", bus.err_o,     1'b0);
        bus.err_clr_i = 1'b1;
        tick();
        bus.err_clr_i = 1'b0;
        check_bit("to_abort_sel",  bus.pSel_o, 1'b0);
        check_bit("to_abort_err",  bus.err_o,  1'b1);
        check_bit("to_abort_done", bus.done_o, 1'b0);
        tick();
        check_bit("to_next_sel", bus.pSel_o, 1'b1);
        check_output("to_next_addr", bus.pAddr_o,      32'h304);
        check_output("to_next_data", bus.pDataWrite_o, 32'h4AAA_0001);
        bus.pReady_i = 1'b1;
        tick();
        check_bit("to_next_en", bus.pEnable_o, 1'b1);
        tick();
        check_bit("to_next_done", bus.done_o, 1'b1);
        check_bit("to_err_sticky", bus.err_o, 1'b1);
        tick();
        check_bit("to_err_sticky2", bus.err_o, 1'b1);
        bus.err_clr_i = 1'b1;
        tick();
        bus.err_clr_i = 1'b0;
        check_bit("to_err_cleared", bus.err_o, 1'b0);

        $display("[TB] reset mid-access");
        bus.pReady_i = 1'b0;
        apply_stimulus(1'b1, 32'h400, 32'h1000_0400);
        tick();
        apply_stimulus(1'b1, 32'h404, 32'h1000_0404);
        tick();
        apply_stimulus(1'b1, 32'h408, 32'h1000_0408);
        tick();
        apply_stimulus(1'b0, 32'h0, 32'h0);
        check_bit("rstmid_en_before", bus.pEnable_o, 1'b1);
        #2 n_rst = 1'b0;
        #1;
        check_bit("rstmid_sel",   bus.pSel_o,      1'b0);
        check_bit("rstmid_en",    bus.pEnable_o,   1'b0);
        check_bit("rstmid_busy",  bus.busy_o,      1'b0);
        check_bit("rstmid_ready", bus.cmd_ready_o, 1'b1);
        tick();
        n_rst = 1'b1;
        bus.pReady_i = 1'b1;
        for (int r = 0; r < 6; r++) begin
            tick();
            check_bit($sformatf("rstmid_idle_sel_%0d", r),  bus.pSel_o, 1'b0);
            check_bit($sformatf("rstmid_idle_busy_%0d", r), bus.busy_o, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gpu_apb_cmd_master.md
Name: gpu_apb_cmd_master

Overview:
APB write initiator that feeds drawing commands into the gpu slave port (pAddr/pDataWrite/pSel/pEnable/pWrite). Upstream logic pushes 32-bit command words through a valid/ready handshake into a small FIFO. A two-phase APB FSM drains the FIFO, honours slave wait states through pReady, aborts stuck transfers on timeout, and can be held off by a stall input.

Parameters:
FIFO_DEPTH, 4, command FIFO entries; power of two, >=2
TIMEOUT, 16, max ACCESS cycles with pReady low before abort; >=1

Ports:
clk  in  1  system clock, rising edge
n_rst  in  1  asynchronous active-low reset
cmd_valid_i  in  1  upstream command valid
cmd_addr_i  in  32  APB address for this command
cmd_data_i  in  32  command word: [31:28] opcode, [18:10] y, [9:0] x, remaining bits opcode-specific
cmd_ready_o  out  1  FIFO can accept; equals !full
stall_i  in  1  blocks start of a new transfer
pReady_i  in  1  slave ready; tie high for a zero-wait slave
pAddr_o  out  32  APB address
pDataWrite_o  out  32  APB write data
pSel_o  out  1  APB select
pEnable_o  out  1  APB enable
pWrite_o  out  1  high whenever pSel_o is high; the block only writes
done_o  out  1  1-cycle pulse per successfully completed transfer
err_o  out  1  sticky timeout flag
err_clr_i  in  1  clears err_o
busy_o  out  1  FIFO non-empty or FSM not IDLE

Behaviour:
- Reset, asynchronous: FIFO emptied, FSM=IDLE. All outputs 0 except cmd_ready_o=1. Reset mid-transfer drops pSel_o/pEnable_o immediately and discards queued commands.
- Push: occurs when cmd_valid_i && cmd_ready_o at a rising edge. cmd_ready_o is derived from registered full only, so a push while full is never accepted, even if a pop happens in the same cycle. Simultaneous push and pop when not full is legal and count is unchanged.
- FSM IDLE -> SETUP: when FIFO non-empty && !stall_i. On entry, pAddr_o/pDataWrite_o load from the FIFO head and pSel_o=1, pWrite_o=1, pEnable_o=0.
- FSM SETUP -> ACCESS: unconditional after 1 cycle. pEnable_o=1. Address and data are held stable through ACCESS.
- In ACCESS with pReady_i=1: transfer completes at that edge. FIFO pops, done_o pulses the next cycle, and the wait counter clears. Next state is SETUP (back-to-back, pSel_o stays high) if the FIFO still holds another entry && !stall_i; otherwise IDLE with pSel_o=pEnable_o=pWrite_o=0.
- In ACCESS with pReady_i=0: the wait counter increments. When it reaches TIMEOUT, the FSM aborts: entry popped, err_o set, no done_o, next state IDLE.
- Latency: push at edge E0 -> pSel_o high after E1 -> pEnable_o high after E2 -> zero-wait completion at E3. Steady-state throughput is 1 word per 2 cycles.
- stall_i: sampled only when deciding to start a transfer. An in-flight transfer always finishes or times out.
- err_clr_i: clears err_o. A timeout in the same cycle as a clear takes priority and err_o stays 1.
- pAddr_o/pDataWrite_o: hold their last values when idle. The bench checks them only while pSel_o=1.
- FIFO pointers: log2(FIFO_DEPTH) bits plus one wrap bit; full and empty are derived from the wrap bit. The wait counter is clog2(TIMEOUT+1) bits and saturates.

Decomposition:
- Package gpu_cmd_pkg:
  - opcode constants CMD_SET_XY1=4'b0001, CMD_SET_XY2=4'b0010, CMD_DRAW_LINE=4'b0100
  - field positions OP_MSB/LSB=31/28, Y_MSB/LSB=18/10, X_MSB/LSB=9/0
  - FSM state enum {IDLE, SETUP, ACCESS}
- Sub-module cmd_fifo: 64-bit wide (addr+data), synchronous push/pop, full/empty outputs. The top level holds the FSM, timeout counter and error logic.

Test Plan:
- Single zero-wait write: push addr 0, data 0x1000_0000 with pReady=1 -> pSel_o after 1 cycle, pEnable_o after 2, done_o 1 pulse, busy_o back to 0; total 4 cycles from push.
- Back-to-back triple (0x1000_0000, 0x2002_A4C8 [x=200,y=169], 0x40AA_BD3E): pSel_o held high for 6 cycles, pEnable_o alternating 0/1, exactly 3 done_o pulses, data order preserved.
- FIFO full: push 6 words while stall_i=1 -> cmd_ready_o low after the 4th push, words 5-6 not accepted. Release stall -> exactly 4 transfers.
- Wait states: pReady_i low 3 ACCESS cycles then high -> pAddr_o/pDataWrite_o stable throughout, done_o once, no err_o.
- Timeout: pReady_i held 0 -> abort after 16 ACCESS cycles, pSel_o=0, err_o=1 and sticky, the next queued word proceeds normally. Pulse err_clr_i -> err_o=0.
- Reset mid-ACCESS with 2 queued: n_rst low -> pSel_o/pEnable_o drop asynchronously, busy_o=0. After release, no transfer occurs without a new push.
